// File: rtl/memory_responder_if.sv
// Request/response bus between the datapath (MAR/MDR side) and the memory responder.
// Handshake: the master holds Read or Write until MemReady is seen high, then drops both; MemReady falls on the edge that samples them low.
interface memory_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] Mdatain;
    logic              MemReady;
    logic              Error;

    modport master (
        output Read, Write, Address, DataIn,
        input  Mdatain, MemReady, Error
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output Mdatain, MemReady, Error
    );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory answering MAR/MDR requests after WAIT_STATES extra cycles,
// with a four-phase ready handshake and a one-cycle Error pulse for conflicting requests.
module memory_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    memory_responder_if.slave    bus,
    output logic [1:0]           state_o
);
    // Debug encoding on state_o: 0 = IDLE, 1 = WAIT, 2 = RESP.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              mem_we;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = ready_q;
        error_d    = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                if (bus.Read ^ bus.Write) begin
                    op_write_d = bus.Write;
                    addr_d     = bus.Address;
                    wdata_d    = bus.DataIn;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = S_WAIT;
                end else if (bus.Read && bus.Write) begin
                    error_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (op_write_q) mem_we  = 1'b1;
                    else            rdata_d = mem[addr_q];
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A request still held here is the tail of the current access, not a new one.
                if (!bus.Read && !bus.Write) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    // Array keeps its contents through reset; reset forces IDLE so no write fires.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.Mdatain  = rdata_q;
    assign bus.MemReady = ready_q;
    assign bus.Error    = error_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_memory_responder.sv
// Randomized scoreboard bench for memory_responder: a sparse reference memory predicts
// Mdatain at every MemReady rise, plus directed reset, error and hold sequences.
module tb_memory_responder;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int WS      = 2;
    localparam int LATENCY = WS + 1;

    logic       clock;
    logic       clear;
    logic [1:0] state;

    memory_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
        .clock   (clock),
        .clear   (clear),
        .bus     (bus),
        .state_o (state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] last_read;
    int                written_addrs[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: each MemReady rise consumes one expected Mdatain value
    logic prev_ready = 1'b0;
    always @(negedge clock) begin
        if (bus.MemReady === 1'b1 && prev_ready !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                check("mdatain", bus.Mdatain, exp_q.pop_front());
            end
        end
        prev_ready <= bus.MemReady;
    end

    // driver: one full four-phase access; mut_addr >= 0 rewrites Address during WAIT
    task automatic do_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int hold, input int mut_addr);
        int n;
        if (wr) begin
            exp_q.push_back(last_read);
            ref_mem[int'(a)] = d;
            written_addrs.push_back(int'(a));
        end else begin
            last_read = ref_mem[int'(a)];
            exp_q.push_back(last_read);
        end
        @(negedge clock);
        bus.Read    = !wr;
        bus.Write   = wr;
        bus.Address = a;
        bus.DataIn  = d;
        @(posedge clock);
        #1;
        if (mut_addr >= 0) begin
            bus.Address = ADDR_W'(mut_addr);
            bus.DataIn  = $urandom;
        end
        n = 0;
        while (bus.MemReady !== 1'b1 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(LATENCY));
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            #1;
        end
        if (hold > 0) check("ready_held", 32'(bus.MemReady), 32'd1);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        @(posedge clock);
        #1;
        check("ready_drop", 32'(bus.MemReady), 32'd0);
        check("back_idle", 32'(state), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        last_read   = '0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.Address = '0;
        bus.DataIn  = '0;
        clear       = 1'b0;
        #1;
        check("rst_mdatain", bus.Mdatain, 32'd0);
        check("rst_ready", 32'(bus.MemReady), 32'd0);
        check("rst_error", 32'(bus.Error), 32'd0);
        repeat (2) @(negedge clock);
        clear = 1'b1;

        // write/read address 5, then address-change-during-wait
        do_access(1'b1, 9'd5, 32'h1234_5678, 0, -1);
        do_access(1'b0, 9'd5, 32'h0, 0, -1);
        do_access(1'b1, 9'd9, 32'h9999_0009, 0, -1);
        do_access(1'b0, 9'd5, 32'h0, 1, 9);

        // conflicting request
        @(negedge clock);
        bus.Read  = 1'b1;
        bus.Write = 1'b1;
        @(posedge clock);
        #1;
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        check("error_pulse", 32'(bus.Error), 32'd1);
        check("error_no_ready", 32'(bus.MemReady), 32'd0);
        @(posedge clock);
        #1;
        check("error_one_cycle", 32'(bus.Error), 32'd0);
        check("error_still_idle", 32'(state), 32'd0);
        do_access(1'b0, 9'd5, 32'h0, 0, -1);

        // reset during WAIT aborts a write to address 7
        do_access(1'b1, 9'd7, 32'h0BAD_F00D, 0, -1);
        @(negedge clock);
        bus.Write   = 1'b1;
        bus.Address = 9'd7;
        bus.DataIn  = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        bus.Write = 1'b0;
        check("abort_mdatain", bus.Mdatain, 32'd0);
        check("abort_ready", 32'(bus.MemReady), 32'd0);
        check("abort_error", 32'(bus.Error), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        last_read = '0;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        do_access(1'b0, 9'd7, 32'h0, 0, -1);

        // request held 10 cycles past MemReady: one access only
        do_access(1'b0, 9'd9, 32'h0, 10, -1);

        // boundary addresses
        do_access(1'b1, 9'd511, 32'hA5A5_A5A5, 0, -1);
        do_access(1'b1, 9'd0, 32'h5A5A_5A5A, 0, -1);
        do_access(1'b0, 9'd511, 32'h0, 0, -1);
        do_access(1'b0, 9'd0, 32'h0, 0, -1);

        // random traffic
        n_acc = 40;
        for (int i = 0; i < n_acc; i++) begin
            bit                wr;
            logic [ADDR_W-1:0] a;
            int                mut;
            wr  = ($urandom_range(0, 1) == 1);
            mut = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 511)) : -1;
            if (wr) a = ADDR_W'($urandom_range(0, 511));
            else    a = ADDR_W'(written_addrs[$urandom_range(0, written_addrs.size() - 1)]);
            do_access(wr, a, $urandom, $urandom_range(0, 3), mut);
        end

        repeat (3) @(posedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits.
REQ-002 Parameter ADDR_W, default 9, address width; depth is 2^ADDR_W words (512).
REQ-003 Parameter WAIT_STATES, default 2, extra access cycles inserted before a response (legal range 0..15).
REQ-004 clock  input  1  single clock; all state updates occur on the rising edge.
REQ-005 clear  input  1  reset, asynchronous, active-low.
REQ-006 Read  input  1  read request from the datapath MDR/MAR side.
REQ-007 Write  input  1  write request from the datapath MDR/MAR side.
REQ-008 Address  input  ADDR_W  word address, driven from MAR.
REQ-009 DataIn  input  DATA_W  write data, driven from MDR.
REQ-010 Mdatain  output  DATA_W  read data returned to the MDR input mux.
REQ-011 MemReady  output  1  response valid / access complete.
REQ-012 Error  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-013 The block SHALL implement a 3-state FSM: IDLE, WAIT, RESP; the state register, wait counter, latched request, Mdatain, MemReady and Error SHALL all be registered.
REQ-014 IDLE: on an edge with exactly one of Read/Write high, the block SHALL latch Address, DataIn and the operation, load cnt=WAIT_STATES and enter WAIT.
REQ-015 IDLE: on an edge with Read and Write both high, the block SHALL stay in IDLE, perform no access, and assert Error for exactly one cycle.
REQ-016 WAIT: each edge with cnt>0 SHALL decrement cnt; the edge with cnt==0 SHALL perform the access and enter RESP.
REQ-017 Access, write: mem[latched Address] <= latched DataIn; Mdatain SHALL be unchanged.
REQ-018 Access, read: Mdatain <= mem[latched Address]; the memory SHALL be unchanged.
REQ-019 Latency: MemReady SHALL rise after edge k+WAIT_STATES+1, where k is the accepting edge (3 edges with the default).
REQ-020 RESP: MemReady SHALL be held high until an edge samples Read=0 and Write=0, then the FSM SHALL return to IDLE with MemReady low (full 4-phase handshake).
REQ-021 Request, Address and DataIn changes during WAIT or RESP SHALL be ignored; only latched values are used.
REQ-022 A request held high through RESP SHALL NOT start a second access; a new access requires a return to IDLE.
REQ-023 Mdatain SHALL hold the most recent completed read value indefinitely.
REQ-024 All 2^ADDR_W addresses, 0 through 511, SHALL be valid; there is no out-of-range condition and no address wrap.
REQ-025 WAIT_STATES=0 SHALL give a 1-edge latency: accept, then access on the next edge.

Reset
REQ-026 With clear low, the block SHALL asynchronously force state=IDLE, cnt=0, Mdatain=0, MemReady=0, Error=0.
REQ-027 Memory array contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted during WAIT SHALL abort the access, and a pending write SHALL NOT modify the array.
REQ-029 After clear deasserts, the first rising edge SHALL be treated as a normal IDLE edge.

Verification
REQ-030 Write 0x12345678 to address 5, complete the handshake, then read address 5 -> Mdatain=0x12345678, and MemReady rises 3 edges after each accept.
REQ-031 Read and Write high together in IDLE -> Error high for exactly 1 cycle, MemReady stays 0, and address 5 still reads back 0x12345678.
REQ-032 Write 0xDEADBEEF to address 7, and pull clear low during WAIT -> all outputs 0, and a later read of address 7 returns its prior content, not 0xDEADBEEF.
REQ-033 Read held high for 10 cycles after MemReady -> MemReady stays high and exactly one access occurs; after Read drops, the FSM is in IDLE on the next edge.
REQ-034 Write 0xA5A5A5A5 to address 511 and 0x5A5A5A5A to address 0, then read both -> 0xA5A5A5A5 and 0x5A5A5A5A respectively.
REQ-035 Change Address from 5 to 9 during WAIT of a read -> the returned data comes from address 5.
